switch_debounce: RTL and testbench
==================================

# switch_debounce

Multi-channel switch debouncer that sits directly upstream of the switch-to-LED stage on the Go Board. It synchronises the raw, bouncing push-button inputs into the 25 MHz `i_Clk` domain and filters them so that only changes held for a programmable number of cycles pass through. It drives a clean level per switch plus one-cycle press and release pulses for later counter and toggle stages.

## Interface
- `NUM_SWITCHES`, default 4: number of independent channels.
- `DEBOUNCE_LIMIT`, default 250000: consecutive stable cycles required before a change is accepted (10 ms at 25 MHz). Legal range is 2 or more; simulation uses 4.
- `i_Clk`, input, 1: system clock, 25 MHz. This is the only clock.
- `i_Rst_L`, input, 1: reset, asynchronous assert, active-low.
- `i_Switch`, input, NUM_SWITCHES: raw switch levels, asynchronous, 1 = pressed.
- `o_Switch`, output, NUM_SWITCHES: debounced level per channel.
- `o_Press`, output, NUM_SWITCHES: one-cycle pulse when `o_Switch[n]` goes 0→1.
- `o_Release`, output, NUM_SWITCHES: one-cycle pulse when `o_Switch[n]` goes 1→0.

## Operation
- Each channel is independent; channels share no state.
- **Synchroniser:** two flip-flops per channel. `sync2` is the filtered input.
- **Counter:** one per channel, width `$clog2(DEBOUNCE_LIMIT)`, unsigned. It never wraps.
- **Per-channel state machine (two states, held in the `o_Switch` bit):**
  - STABLE_LOW / STABLE_HIGH. In either state, `sync2` equal to the state clears the counter to 0.
  - If `sync2` differs from the state and the counter is below `DEBOUNCE_LIMIT-1`, the counter increments.
  - If `sync2` differs and the counter equals `DEBOUNCE_LIMIT-1`, the state flips, the counter clears to 0, and the matching press or release register is set for that one cycle.
- **Bounce:** any single cycle where `sync2` returns to the state value restarts the count from 0. Glitches shorter than `DEBOUNCE_LIMIT` cycles never reach `o_Switch`.
- **Pulses:** `o_Press` and `o_Release` are registered. Each is high for exactly one cycle, coincident with the first cycle of the new `o_Switch` value. They are never high together on the same channel.
- **Reset:** while `i_Rst_L` = 0, all synchroniser bits, counters, `o_Switch`, `o_Press` and `o_Release` are 0. Assertion takes effect immediately, mid-count included, and any in-progress count is discarded.
- **Reset release with a switch held:** the state starts at 0, so a press is reported after the normal latency. This is required behaviour.

## Timing
- **Latency:** `i_Switch` changes before edge k. `sync1` captures at k and `sync2` at k+1. `o_Switch` and the pulse update at edge k+1+`DEBOUNCE_LIMIT`, provided the input is stable throughout.
- **Minimum accepted pulse width:** `DEBOUNCE_LIMIT` cycles of stable `sync2`.
- **Minimum spacing between two accepted transitions on one channel:** `DEBOUNCE_LIMIT` cycles.
- **Outputs:** all are registered, with no combinational path from `i_Switch`.
- **Reset deassertion:** must meet recovery relative to `i_Clk`. The board-level reset synchroniser guarantees this; this block does not re-synchronise reset.

## Structure
- **Shared package `go_board_pkg`:**
  - `CLK_FREQ_HZ` = 25_000_000
  - `DEBOUNCE_MS` = 10
  - derived `DEBOUNCE_CYCLES`, used as the top-level default
  - `NUM_SWITCHES` = 4
- **Sub-module `debounce_channel`:** single-bit, containing the synchroniser, counter, state and pulse registers. `switch_debounce` instantiates it `NUM_SWITCHES` times in a generate loop.
- **Downstream:** the switch-to-LED stage consumes `o_Switch` directly.

## Test plan
All scenarios use `DEBOUNCE_LIMIT` = 4.
- **Clean press:** `i_Switch[0]` 0→1 before edge 0 and held → `o_Switch[0]`=1 and `o_Press[0]`=1 at edge 5 only. `o_Press[0]`=0 at edge 6. Other channels stay 0.
- **Bounce:** `i_Switch[1]` toggles 1,0,1,0 on successive cycles, then holds 1 → no output change during the toggling. `o_Switch[1]` rises exactly 5 edges after the final 0→1.
- **Release and spacing:** press held 10 cycles, then released and held 0 → one `o_Press` pulse and one `o_Release` pulse, the release at 5 edges after the input fall. A 3-cycle release glitch produces no pulse.
- **Simultaneous:** all four inputs rise on the same cycle → all `o_Switch` bits and `o_Press` = 4'b1111 on the same edge.
- **Reset mid-count:** `i_Rst_L` asserted 2 cycles into a count → all outputs are 0 immediately (asynchronous, before the next edge). After release with the input still 1, the press is reported `DEBOUNCE_LIMIT`+2 edges later.
- **Reset release with switch held:** `i_Switch`=4'b1010 held through reset → after deassertion, `o_Switch`=4'b1010 with a single `o_Press`=4'b1010 pulse at edge 5.

Source files
------------

// File: rtl/go_board_pkg.sv
// Shared Go Board constants and types.
// Clock rate, debounce timing and switch count live here.
package go_board_pkg;

    localparam int CLK_FREQ_HZ  = 25_000_000;
    localparam int DEBOUNCE_MS  = 10;
    localparam int NUM_SWITCHES = 4;

    // Milliseconds to clock cycles at a given clock rate.
    function automatic int ms_to_cycles(
        input int clk_hz,
        input int ms
    );
        return (clk_hz / 1000) * ms;
    endfunction

    localparam int DEBOUNCE_CYCLES =
        ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);

    // The state value is the debounced level itself.
    typedef enum logic {
        STABLE_LOW  = 1'b0,
        STABLE_HIGH = 1'b1
    } db_state_e;

endpackage

// File: rtl/debounce_channel.sv
// Single-bit switch debouncer.
// Synchroniser, stability counter, level state and pulse flops.
module debounce_channel
    import go_board_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_CYCLES
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Press,
    output logic o_Release
);

    localparam int CNT_W = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX =
        CNT_W'(DEBOUNCE_LIMIT - 1);

    logic             sync1;
    logic             sync2;
    db_state_e        state;
    db_state_e        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             press_nxt;
    logic             release_nxt;

    // Bring the asynchronous switch level into the clock domain.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= i_Switch;
            sync2 <= sync1;
        end
    end

    // Level state, stability counter and one-cycle pulse registers.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state     <= STABLE_LOW;
            cnt       <= '0;
            o_Press   <= 1'b0;
            o_Release <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            o_Press   <= press_nxt;
            o_Release <= release_nxt;
        end
    end

    // Count consecutive disagreeing cycles; flip once the limit is hit.
    // Any agreeing cycle clears the count, so bounces restart it.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = '0;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        unique case (state)
            STABLE_LOW: begin
                if (sync2) begin
                    if (cnt == CNT_MAX) begin
                        state_nxt = STABLE_HIGH;
                        press_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            STABLE_HIGH: begin
                if (!sync2) begin
                    if (cnt == CNT_MAX) begin
                        state_nxt   = STABLE_LOW;
                        release_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
        endcase
    end

    assign o_Switch = state;

endmodule

// File: rtl/switch_debounce.sv
// Multi-channel push-button debouncer.
// One independent debounce_channel per switch.
module switch_debounce #(
    parameter int NUM_SWITCHES   = go_board_pkg::NUM_SWITCHES,
    parameter int DEBOUNCE_LIMIT = go_board_pkg::DEBOUNCE_CYCLES
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic [NUM_SWITCHES-1:0] i_Switch,
    output logic [NUM_SWITCHES-1:0] o_Switch,
    output logic [NUM_SWITCHES-1:0] o_Press,
    output logic [NUM_SWITCHES-1:0] o_Release
);

    for (genvar n = 0; n < NUM_SWITCHES; n++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)
        ) u_ch (
            .i_Clk    (i_Clk),
            .i_Rst_L  (i_Rst_L),
            .i_Switch (i_Switch[n]),
            .o_Switch (o_Switch[n]),
            .o_Press  (o_Press[n]),
            .o_Release(o_Release[n])
        );
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce with a debounce limit of 4.
// Per-cycle vectors feed a queue of expected outputs.
module tb_switch_debounce;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw_in;
    logic [3:0] o_sw;
    logic [3:0] o_pr;
    logic [3:0] o_rl;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rst;
        logic [3:0] sw;
        logic [3:0] es;
        logic [3:0] ep;
        logic [3:0] er;
    } vec_t;

    typedef struct packed {
        logic [3:0] sw;
        logic [3:0] pr;
        logic [3:0] rl;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    switch_debounce #(
        .NUM_SWITCHES  (4),
        .DEBOUNCE_LIMIT(4)
    ) dut (
        .i_Clk    (clk),
        .i_Rst_L  (rst_n),
        .i_Switch (sw_in),
        .o_Switch (o_sw),
        .o_Press  (o_pr),
        .o_Release(o_rl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cmp(input string nm, input logic [3:0] act,
                       input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] sw,
                       input logic [3:0] es, input logic [3:0] ep,
                       input logic [3:0] er);
        vec_t v;
        v.rst = r;
        v.sw  = sw;
        v.es  = es;
        v.ep  = ep;
        v.er  = er;
        vecs.push_back(v);
    endtask

    task automatic rep(input int n, input logic [3:0] sw,
                       input logic [3:0] es);
        for (int i = 0; i < n; i++) add(1'b1, sw, es, 4'b0, 4'b0);
    endtask

    task automatic step(input logic r, input logic [3:0] sw,
                        input logic [3:0] es, input logic [3:0] ep,
                        input logic [3:0] er, input string tag);
        exp_t e;
        @(negedge clk);
        rst_n = r;
        sw_in = sw;
        e.sw = es;
        e.pr = ep;
        e.rl = er;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        cmp({tag, " o_Switch"}, o_sw, e.sw);
        cmp({tag, " o_Press"}, o_pr, e.pr);
        cmp({tag, " o_Release"}, o_rl, e.rl);
    endtask

    initial begin
        rst_n = 1'b0;
        sw_in = 4'b0000;

        // idle after reset release
        rep(2, 4'b0000, 4'b0000);
        // clean press and release on channel 0
        add(1, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        rep(4, 4'b0001, 4'b0000);
        add(1, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
        add(1, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        add(1, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
        rep(4, 4'b0000, 4'b0001);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // bounce 1,0,1,0 then hold on channel 1
        add(1, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        add(1, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        rep(4, 4'b0010, 4'b0000);
        add(1, 4'b0010, 4'b0010, 4'b0010, 4'b0000);
        add(1, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
        add(1, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
        rep(4, 4'b0000, 4'b0010);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // channel 2: press, hold, 3-cycle release glitch, release
        add(1, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        rep(4, 4'b0100, 4'b0000);
        add(1, 4'b0100, 4'b0100, 4'b0100, 4'b0000);
        rep(4, 4'b0100, 4'b0100);
        rep(3, 4'b0000, 4'b0100);
        rep(7, 4'b0100, 4'b0100);
        add(1, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
        rep(4, 4'b0000, 4'b0100);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // all four together
        add(1, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        rep(4, 4'b1111, 4'b0000);
        add(1, 4'b1111, 4'b1111, 4'b1111, 4'b0000);
        add(1, 4'b1111, 4'b1111, 4'b0000, 4'b0000);
        add(1, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
        rep(4, 4'b0000, 4'b1111);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        // press channel 3 ahead of the reset test
        add(1, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
        rep(4, 4'b1000, 4'b0000);
        add(1, 4'b1000, 4'b1000, 4'b1000, 4'b0000);
        add(1, 4'b1000, 4'b1000, 4'b0000, 4'b0000);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        cmp("reset o_Switch", o_sw, 4'b0000);
        cmp("reset o_Press", o_pr, 4'b0000);
        cmp("reset o_Release", o_rl, 4'b0000);

        foreach (vecs[i])
            step(vecs[i].rst, vecs[i].sw, vecs[i].es,
                 vecs[i].ep, vecs[i].er, $sformatf("vec%0d", i));

        // channel 0 count reaches 2, then reset mid-cycle
        for (int i = 0; i < 4; i++)
            step(1'b1, 4'b1001, 4'b1000, 4'b0000, 4'b0000,
                 $sformatf("midcnt%0d", i));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        cmp("async rst o_Switch", o_sw, 4'b0000);
        cmp("async rst o_Press", o_pr, 4'b0000);
        cmp("async rst o_Release", o_rl, 4'b0000);
        for (int i = 0; i < 2; i++)
            step(1'b0, 4'b1001, 4'b0000, 4'b0000, 4'b0000,
                 $sformatf("inrst%0d", i));
        for (int i = 0; i < 5; i++)
            step(1'b1, 4'b1001, 4'b0000, 4'b0000, 4'b0000,
                 $sformatf("postrst%0d", i));
        step(1'b1, 4'b1001, 4'b1001, 4'b1001, 4'b0000, "postrst5");
        step(1'b1, 4'b1001, 4'b1001, 4'b0000, 4'b0000, "postrst6");

        // 1010 held through reset
        for (int i = 0; i < 3; i++)
            step(1'b0, 4'b1010, 4'b0000, 4'b0000, 4'b0000,
                 $sformatf("held_rst%0d", i));
        for (int i = 0; i < 5; i++)
            step(1'b1, 4'b1010, 4'b0000, 4'b0000, 4'b0000,
                 $sformatf("held%0d", i));
        step(1'b1, 4'b1010, 4'b1010, 4'b1010, 4'b0000, "held5");
        step(1'b1, 4'b1010, 4'b1010, 4'b0000, 4'b0000, "held6");
        step(1'b1, 4'b1010, 4'b1010, 4'b0000, 4'b0000, "held7");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
